// File: rtl/pipe_gen_if.sv
// Pipe generator handshake bundle: scroll tick, player/game inputs and
// the generated pipe column, spawn strobe and score.
interface pipe_gen_if;
    logic        clk;
    logic        start;
    logic        gameover;
    logic [15:0] newPipe;
    logic        clkP;
    logic [7:0]  score;

    modport master (
        output clk, start, gameover,
        input  newPipe, clkP, score
    );

    modport slave (
        input  clk, start, gameover,
        output newPipe, clkP, score
    );
endinterface

// File: rtl/pipe_gen.sv
// Pipe column generator: LFSR-placed gap, spawn timing and WAIT/RUN/DEAD control.
// Optional macro PIPE_GEN_SCORE_EN enables the saturating spawn score counter.
module pipe_gen #(
    parameter int unsigned GAP_W        = 4,
    parameter int unsigned SPAWN_PERIOD = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clkM,
    input  logic       reset,
    pipe_gen_if.slave  bus
);
    typedef enum logic [1:0] {
        WAIT = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [7:0]  CNT_LAST = 8'(SPAWN_PERIOD - 1);
    localparam logic [7:0]  POS_MOD  = 8'(17 - GAP_W);
    localparam logic [15:0] GAP_ONES = 16'((32'd1 << GAP_W) - 32'd1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] pipe_q, pipe_d;
    logic [7:0]  pos;
    logic [15:0] pattern;
    logic        spawn;

    always_comb begin
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        pos     = lfsr_q[7:0] % POS_MOD;
        pattern = ~(GAP_ONES << pos);
        state_d = state_q;
        cnt_d   = cnt_q;
        pipe_d  = pipe_q;
        // Reset gating keeps a spawn that coincides with reset from escaping.
        spawn   = bus.clk && (state_q == RUN) && (cnt_q == CNT_LAST)
                  && !bus.gameover && !reset;

        case (state_q)
            WAIT: begin
                pipe_d = pattern;
                if (bus.start && !bus.gameover) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (bus.clk)
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 8'd1;
                if (spawn)
                    pipe_d = pattern;
                if (bus.gameover)
                    state_d = DEAD;
            end
            DEAD: begin
                if (!bus.gameover)
                    state_d = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clkM) begin
        if (reset) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            pipe_q  <= pipe_d;
        end
    end

    assign bus.newPipe = pipe_q;
    assign bus.clkP    = spawn;

`ifdef PIPE_GEN_SCORE_EN
    logic [7:0] score_q, score_d;

    always_comb begin
        score_d = score_q;
        if (state_q == WAIT && state_d == RUN)
            score_d = '0;
        else if (spawn && score_q != 8'hFF)
            score_d = score_q + 8'd1;
    end

    always_ff @(posedge clkM) begin
        if (reset)
            score_q <= '0;
        else
            score_q <= score_d;
    end

    assign bus.score = score_q;
`else
    assign bus.score = '0;
`endif
endmodule

// File: tb/tb_pipe_gen.sv
// Directed bench for pipe_gen: table of per-cycle vectors plus long spawn runs.
module tb_pipe_gen;
`ifdef PIPE_GEN_SCORE_EN
    localparam bit SC_EN = 1'b1;
`else
    localparam bit SC_EN = 1'b0;
`endif
    localparam int ST_W = 0, ST_R = 1, ST_D = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clkM = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    pipe_gen_if bus0 ();
    pipe_gen_if bus1 ();

    always #5 clkM = ~clkM;

    pipe_gen dut0 (.clkM(clkM), .reset(rst0), .bus(bus0));
    pipe_gen #(.GAP_W(8), .SPAWN_PERIOD(2)) dut1 (.clkM(clkM), .reset(rst1), .bus(bus1));

    typedef struct {
        bit rst, clk, st, go;
        bit exp_clkp, exp_ld;
        int exp_state, exp_score;
    } vec_t;
    vec_t vecs[$];

    int passed = 0, total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input bit rst, input bit clk, input bit st, input bit go,
                       input bit cp, input bit ld, input int s, input int sc);
        vec_t v;
        v.rst = rst; v.clk = clk; v.st = st; v.go = go;
        v.exp_clkp = cp; v.exp_ld = ld; v.exp_state = s; v.exp_score = sc;
        vecs.push_back(v);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] m);
        logic [15:0] r;
        r = m >> 1;
        if (m[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [15:0] pat(input logic [15:0] m, input int w);
        logic [15:0] r;
        int p;
        p = int'(m[7:0]) % (17 - w);
        r = 16'hFFFF;
        for (int b = p; b < p + w; b++) r[b] = 1'b0;
        return r;
    endfunction

    function automatic bit gap_ok(input logic [15:0] p, input int w);
        int z, first;
        z = 0; first = -1;
        for (int b = 0; b < 16; b++)
            if (!p[b]) begin
                z++;
                if (first < 0) first = b;
            end
        if (z != w || first < 0 || first > 16 - w) return 1'b0;
        for (int b = first; b < first + w; b++)
            if (p[b]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        logic [15:0] m, exp_np;
        int pulses, bad, first_pulse, spawns, bad_sc;
        bit pend;
        bus0.clk = 0; bus0.start = 0; bus0.gameover = 0;
        bus1.clk = 0; bus1.start = 0; bus1.gameover = 0;
        m = SEED; exp_np = '0;

        // Vector table: reset, WAIT, first spawn, gameover-vs-spawn, resets in RUN.
        add(1,0,0,0, 0,0,ST_W,0);
        add(0,0,0,0, 0,1,ST_W,0);
        add(0,0,1,1, 0,1,ST_W,0);
        add(0,0,1,0, 0,1,ST_R,0);
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < 3; j++) add(0,0,0,0, 0,0,ST_R,0);
            add(0,1,0,0, k == 8, k == 8, ST_R, (k == 8) ? 1 : 0);
        end
        for (int k = 9; k <= 15; k++) begin
            for (int j = 0; j < 3; j++) add(0,0,0,0, 0,0,ST_R,1);
            add(0,1,0,0, 0,0,ST_R,1);
        end
        for (int j = 0; j < 3; j++) add(0,0,0,0, 0,0,ST_R,1);
        add(0,1,0,1, 0,0,ST_D,1);
        add(0,0,0,1, 0,0,ST_D,1);
        add(0,0,0,0, 0,0,ST_W,1);
        add(0,0,0,0, 0,1,ST_W,1);
        add(0,0,1,0, 0,1,ST_R,0);
        for (int j = 0; j < 7; j++) add(0,1,0,0, 0,0,ST_R,0);
        add(1,1,0,0, 0,0,ST_W,0);
        add(0,0,0,0, 0,1,ST_W,0);
        add(0,0,1,0, 0,1,ST_R,0);
        for (int j = 0; j < 5; j++) add(0,1,0,0, 0,0,ST_R,0);
        add(1,1,0,0, 0,0,ST_W,0);

        @(posedge clkM); #1;
        foreach (vecs[i]) begin
            rst0 = vecs[i].rst; bus0.clk = vecs[i].clk;
            bus0.start = vecs[i].st; bus0.gameover = vecs[i].go;
            @(negedge clkM);
            check($sformatf("clkP[%0d]", i), 32'(bus0.clkP), 32'(vecs[i].exp_clkp));
            if (vecs[i].rst) exp_np = '0;
            else if (vecs[i].exp_ld) exp_np = pat(m, 4);
            @(posedge clkM); #1;
            m = vecs[i].rst ? SEED : lfsr_next(m);
            check($sformatf("newPipe[%0d]", i), 32'(bus0.newPipe), 32'(exp_np));
            check($sformatf("state[%0d]", i), 32'(dut0.state_q), 32'(vecs[i].exp_state));
            check($sformatf("score[%0d]", i), 32'(bus0.score), SC_EN ? 32'(vecs[i].exp_score) : 32'd0);
            if (i == 1)
                check("gap4_after_reset", 32'(gap_ok(bus0.newPipe, 4)), 32'd1);
        end
        check("cnt_after_reset", 32'(dut0.cnt_q), 32'd0);

        // 302 spawns with the tick held high: score saturates (or stays 0).
        rst0 = 1; bus0.clk = 0; bus0.start = 0; bus0.gameover = 0;
        @(posedge clkM); #1; rst0 = 0;
        @(posedge clkM); #1; bus0.start = 1;
        @(posedge clkM); #1; bus0.start = 0; bus0.clk = 1;
        pulses = 0; bad = 0; bad_sc = 0; first_pulse = -1;
        for (int i = 0; i < 2416; i++) begin
            @(negedge clkM);
            if (bus0.score !== (SC_EN ? 8'((pulses > 255) ? 255 : pulses) : 8'd0)) bad_sc++;
            if (bus0.clkP !== ((i % 8) == 7)) bad++;
            if (bus0.clkP === 1'b1) begin
                if (first_pulse < 0) first_pulse = i;
                pulses++;
            end
            @(posedge clkM); #1;
        end
        check("first_spawn_tick", 32'(first_pulse), 32'd7);
        check("spawn_pattern_errs", 32'(bad), 32'd0);
        check("score_track_errs", 32'(bad_sc), 32'd0);
        check("spawn_count", 32'(pulses), 32'd302);
        check("score_saturated", 32'(bus0.score), SC_EN ? 32'd255 : 32'd0);
        bus0.clk = 0;

        // GAP_W=8, period 2: every spawned column must be a legal 8-wide gap.
        rst1 = 1;
        @(posedge clkM); #1; rst1 = 0;
        @(posedge clkM); #1;
        check("gap8_wait", 32'(gap_ok(bus1.newPipe, 8)), 32'd1);
        bus1.start = 1;
        @(posedge clkM); #1; bus1.start = 0; bus1.clk = 1;
        spawns = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clkM);
            pend = (bus1.clkP === 1'b1);
            @(posedge clkM); #1;
            if (pend) begin
                spawns++;
                check($sformatf("gap8_spawn%0d", spawns),
                      32'(gap_ok(bus1.newPipe, 8) && bus1.newPipe != 16'hFFFF
                          && bus1.newPipe != 16'h0000), 32'd1);
            end
        end
        check("gap8_spawn_count", 32'(spawns), 32'd1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
